display_sweep_ctrl: RTL and testbench
=====================================

# display_sweep_ctrl

Sequencer and arbiter for the shared display-monitor value path. Two requesters compete for the display. The winner gets a sweep of `disp_val` from 0 up to its own limit, with each value held for `HOLD` clocks, then a one-cycle completion pulse. Contested requests are granted round-robin, so neither requester can starve the other.

## Interface

Parameters:
- `WIDTH`, default 8: width of the display value and the limits.
- `HOLD`, default 4: clocks each value is held. Legal range is ≥1 and ≤255.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req0`, in, 1: requester 0 wants the display. Level, held until `done` or abort.
- `req1`, in, 1: requester 1 wants the display. Same rules as `req0`.
- `lim0`, in, WIDTH: last value of requester 0's sweep. Sampled only at grant.
- `lim1`, in, WIDTH: last value of requester 1's sweep. Sampled only at grant.
- `gnt`, out, 2: one-hot grant; bit n set means requester n owns the display.
- `disp_val`, out, WIDTH: current value driven to the display monitor.
- `disp_valid`, out, 1: `disp_val` is meaningful.
- `done`, out, 1: one-cycle pulse after the last value's hold completes.
- `busy`, out, 1: high in GRANT/SWEEP/DONE.

## Operation

- Reset values: `gnt`=0, `disp_val`=0, `disp_valid`=0, `done`=0, `busy`=0, state=IDLE, `last`=1.
  - `last` is the internal round-robin pointer. Its reset value of 1 means requester 0 wins the first contest.
- IDLE:
  - If exactly one `req` is high, that requester wins.
  - If both are high, the requester ≠ `last` wins.
  - On a win: latch its limit into `lim_q`, set `last` to the winner, go to SWEEP.
- SWEEP:
  - `gnt` is one-hot for the winner; `disp_valid`=1; `busy`=1.
  - Hold counter `hc` counts 0..HOLD-1.
  - When `hc`=HOLD-1 and `disp_val`≠`lim_q`: increment `disp_val` and clear `hc`.
  - When `hc`=HOLD-1 and `disp_val`=`lim_q`: go to DONE.
- DONE (exactly one cycle): `done`=1, `gnt`=0, `disp_valid`=0, `busy`=1, `disp_val` cleared to 0. Next state is IDLE.
- Arithmetic:
  - `disp_val` never wraps. The maximum sweep is 0..2^WIDTH-1 when the limit is all ones.
  - `hc` is sized ⌈log2(HOLD)⌉ (minimum 1 bit).
- Boundary conditions:
  - Limit 0: the value 0 is shown for HOLD cycles, then DONE.
  - Limit 255 (WIDTH=8): 256 values shown, no overflow to 0 before DONE.
  - Limit changing mid-sweep is ignored; only `lim_q` is used.
  - A request arriving during SWEEP/DONE waits; it is evaluated in IDLE.
  - The losing requester keeps its `req` high and wins the next IDLE evaluation.
  - `rst` mid-sweep: all outputs return to reset values immediately (asynchronously), and `last` returns to 1.

## Timing

- `req` sampled at the clock edge in IDLE. On the following cycle `gnt`, `disp_valid`=1 and `disp_val`=0 are all visible, giving a latency of 1 clock.
- Sweep length is (`lim_q`+1)×HOLD clocks of `disp_valid`. Then 1 clock of `done`, then 1 IDLE clock.
- Minimum spacing between back-to-back grants: (`lim_q`+1)×HOLD + 2 clocks.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- `SWEEP_ABORT_EN` defined:
  - In SWEEP, if the granted requester's `req` is low at a clock edge, go straight to IDLE next cycle.
  - Outputs take their reset values, except that `last` keeps the aborted requester.
  - `done` is NOT pulsed.
- `SWEEP_ABORT_EN` undefined: `req` is ignored once granted, and every sweep runs to completion with `done`.

## Test plan

- Single request (HOLD=2): reset, `req0`=1, `lim0`=3 → `gnt`=01 one clock later; `disp_val` 0,0,1,1,2,2,3,3; then `done`=1 for 1 clock with `gnt`=00.
- Contention (HOLD=1): `req0`=`req1`=1 from reset, `lim0`=1, `lim1`=2 → requester 0 sweeps 0,1 then `done`; after IDLE, `gnt`=10 and values 0,1,2 then `done`. Repeat with both still high → requester 0 wins again.
- Edge limits (HOLD=1): `lim0`=0 → single value 0, then `done`. `lim0`=255 → 256 valid cycles ending at 255, no wrap, then `done`.
- Mid-sweep changes: change `lim0` from 5 to 1 during the sweep → sweep still ends at 5. Raise `req1` mid-sweep → `gnt` unchanged until after `done`.
- Reset during SWEEP at `disp_val`=2 → same-cycle asynchronous return: `gnt`=0, `disp_valid`=0, `disp_val`=0; next contest won by requester 0.
- With `SWEEP_ABORT_EN`: drop `req0` while `disp_val`=2 → next cycle IDLE, `gnt`=0, no `done`. Without the macro: same stimulus → sweep completes to `lim0` and `done` pulses.

Source files
------------

// File: rtl/display_sweep_ctrl_if.sv
// Requester <-> display_sweep_ctrl bus.
// Handshake: reqN is a level held until done (or abort); the controller answers with registered gnt/disp_* and a done pulse.
interface display_sweep_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] lim0;
  logic [WIDTH-1:0] lim1;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] disp_val;
  logic             disp_valid;
  logic             done;
  logic             busy;

  modport master (
    output req0, req1, lim0, lim1,
    input  gnt, disp_val, disp_valid, done, busy
  );

  modport slave (
    input  req0, req1, lim0, lim1,
    output gnt, disp_val, disp_valid, done, busy
  );
endinterface

// File: rtl/display_sweep_ctrl.sv
// Round-robin arbiter plus value sweeper for the shared display-monitor path.
// Optional feature macro: SWEEP_ABORT_EN (owner dropping its req mid-sweep returns to IDLE without done).
module display_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  display_sweep_ctrl_if.slave  bus,
  output logic [1:0]           state_dbg
);

  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             last;
  logic [HC_W-1:0]  hc;
  logic [WIDTH-1:0] lim_q;
  logic             win0;
  logic             win1;

  // last names the previous winner, so on contention the other side goes first.
  assign win0 = bus.req0 && (!bus.req1 || last);
  assign win1 = bus.req1 && !win0;

`ifdef SWEEP_ABORT_EN
  logic owner_req;
  assign owner_req = last ? bus.req1 : bus.req0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last           <= 1'b1;
      hc             <= '0;
      lim_q          <= '0;
      bus.gnt        <= 2'b00;
      bus.disp_val   <= '0;
      bus.disp_valid <= 1'b0;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win0 || win1) begin
            state          <= SWEEP;
            last           <= win1;
            lim_q          <= win1 ? bus.lim1 : bus.lim0;
            hc             <= '0;
            bus.gnt        <= win1 ? 2'b10 : 2'b01;
            bus.disp_val   <= '0;
            bus.disp_valid <= 1'b1;
            bus.done       <= 1'b0;
            bus.busy       <= 1'b1;
          end
        end

        SWEEP: begin
`ifdef SWEEP_ABORT_EN
          if (!owner_req) begin
            state          <= IDLE;
            hc             <= '0;
            bus.gnt        <= 2'b00;
            bus.disp_val   <= '0;
            bus.disp_valid <= 1'b0;
            bus.busy       <= 1'b0;
          end else
`endif
          if (hc == HC_MAX) begin
            hc <= '0;
            // Compare before incrementing so an all-ones limit never wraps.
            if (bus.disp_val == lim_q) begin
              state          <= DONE;
              bus.gnt        <= 2'b00;
              bus.disp_val   <= '0;
              bus.disp_valid <= 1'b0;
              bus.done       <= 1'b1;
            end else begin
              bus.disp_val <= bus.disp_val + WIDTH'(1);
            end
          end else begin
            hc <= hc + HC_W'(1);
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          bus.gnt        <= 2'b00;
          bus.disp_val   <= '0;
          bus.disp_valid <= 1'b0;
          bus.done       <= 1'b0;
          bus.busy       <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_display_sweep_ctrl.sv
// Self-checking bench for display_sweep_ctrl: directed scenarios plus a randomized phase,
// all compared cycle by cycle against a transaction-level expected-output queue.
module tb_display_sweep_ctrl;
  localparam int W    = 8;
  localparam int HOLD = 3;

  typedef struct packed {
    logic [1:0]   gnt;
    logic [W-1:0] val;
    logic         valid;
    logic         done;
    logic         busy;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  display_sweep_ctrl_if #(.WIDTH(W)) bus();

  display_sweep_ctrl #(.WIDTH(W), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  out_t       exp_q[$];
  out_t       cur;
  logic [1:0] gnt_order[$];
  logic [1:0] prev_gnt;
  int         checks = 0;
  int         errors = 0;
  int         m_last;
  int         m_owner;
  int         valid_cnt;
  int         done_cnt;
  int         max_val;
  string      phase;

  function automatic out_t mk(input logic [1:0] g, input int v, input logic va,
                              input logic d, input logic b);
    out_t o;
    o.gnt   = g;
    o.val   = W'(v);
    o.valid = va;
    o.done  = d;
    o.busy  = b;
    return o;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    valid_cnt = 0;
    done_cnt  = 0;
    max_val   = 0;
    gnt_order.delete();
  endtask

  // Reference: when idle, arbitrate and enqueue a whole transaction worth of per-cycle outputs.
  task automatic predict();
    int w;
    int lim;
    logic [1:0] g;
    if (exp_q.size() == 0) begin
      w = -1;
      if (bus.req0 && bus.req1) w = 1 - m_last;
      else if (bus.req0)        w = 0;
      else if (bus.req1)        w = 1;
      if (w < 0) begin
        exp_q.push_back(mk(2'b00, 0, 1'b0, 1'b0, 1'b0));
      end else begin
        lim     = (w == 1) ? int'(bus.lim1) : int'(bus.lim0);
        g       = (w == 1) ? 2'b10 : 2'b01;
        m_last  = w;
        m_owner = w;
        for (int v = 0; v <= lim; v++)
          for (int h = 0; h < HOLD; h++)
            exp_q.push_back(mk(g, v, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(2'b00, 0, 1'b0, 1'b1, 1'b1));
        exp_q.push_back(mk(2'b00, 0, 1'b0, 1'b0, 1'b0));
      end
    end
`ifdef SWEEP_ABORT_EN
    else if (cur.valid && !((m_owner == 1) ? bus.req1 : bus.req0)) begin
      exp_q.delete();
      exp_q.push_back(mk(2'b00, 0, 1'b0, 1'b0, 1'b0));
    end
`endif
  endtask

  task automatic check_out();
    out_t got;
    out_t e;
    got.gnt   = bus.gnt;
    got.val   = bus.disp_val;
    got.valid = bus.disp_valid;
    got.done  = bus.done;
    got.busy  = bus.busy;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = mk(2'b00, 0, 1'b0, 1'b0, 1'b0);
    cur = e;
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s t=%0t: got gnt=%b val=%0d vld=%b done=%b busy=%b, expected gnt=%b val=%0d vld=%b done=%b busy=%b",
             phase, $time, got.gnt, got.val, got.valid, got.done, got.busy,
             e.gnt, e.val, e.valid, e.done, e.busy);
    end
    if (got.valid === 1'b1) begin
      valid_cnt++;
      if (int'(got.val) > max_val) max_val = int'(got.val);
    end
    if (got.done === 1'b1) done_cnt++;
    if (got.gnt != 2'b00 && prev_gnt == 2'b00) gnt_order.push_back(got.gnt);
    prev_gnt = got.gnt;
  endtask

  // Called at a negedge with inputs already set for the coming posedge.
  task automatic step();
    predict();
    @(negedge clk);
    check_out();
  endtask

  task automatic drop_owner();
    if (m_owner == 1) bus.req1 = 1'b0;
    else              bus.req0 = 1'b0;
  endtask

  task automatic run_sweep_drop(input int cap);
    int n;
    n = 0;
    do begin
      step();
      if (cur.done) drop_owner();
      n++;
    end while (exp_q.size() != 0 && n < cap);
    chk({phase, "_bound"}, int'(exp_q.size() == 0), 1);
  endtask

  task automatic step_until_val2(input int cap);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(cur.valid && cur.val == W'(2)) && n < cap);
    chk({phase, "_reach_val2"}, int'(cur.valid && cur.val == W'(2)), 1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last   = 1;
    m_owner  = 0;
    cur      = mk(2'b00, 0, 1'b0, 1'b0, 1'b0);
    prev_gnt = 2'b00;
  endtask

  // Assert rst between clock edges and confirm the outputs clear with no edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk(tag, int'({bus.gnt, bus.disp_val, bus.disp_valid, bus.done, bus.busy}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.lim0 = '0;
    bus.lim1 = '0;
    model_reset();
    clear_obs();

    // Reset state
    phase = "reset";
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({bus.gnt, bus.disp_val, bus.disp_valid, bus.done, bus.busy}), 0);
    rst = 1'b0;
    step();

    // Single request, limit 3
    phase = "single";
    clear_obs();
    bus.req0 = 1'b1;
    bus.lim0 = W'(3);
    run_sweep_drop(100);
    chk("single_valid_cycles", valid_cnt, 4 * HOLD);
    chk("single_done_count", done_cnt, 1);
    chk("single_max_val", max_val, 3);

    // Contention from reset: 0, then 1, then 0 again
    phase = "contention";
    async_reset("contention_rst");
    clear_obs();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.lim0 = W'(1);
    bus.lim1 = W'(2);
    repeat (30) step();
    chk("contention_first", int'(gnt_order[0]), 1);
    chk("contention_second", int'(gnt_order[1]), 2);
    chk("contention_third", int'(gnt_order[2]), 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    run_sweep_drop(100);

    // Limit 0
    phase = "lim0";
    clear_obs();
    bus.req0 = 1'b1;
    bus.lim0 = W'(0);
    run_sweep_drop(50);
    chk("lim0_valid_cycles", valid_cnt, HOLD);
    chk("lim0_done_count", done_cnt, 1);

    // Limit all ones: full sweep, no wrap
    phase = "lim255";
    clear_obs();
    bus.req0 = 1'b1;
    bus.lim0 = W'(255);
    run_sweep_drop(1000);
    chk("lim255_valid_cycles", valid_cnt, 256 * HOLD);
    chk("lim255_max_val", max_val, 255);
    chk("lim255_done_count", done_cnt, 1);

    // Limit changed and req1 raised mid-sweep
    phase = "midchange";
    clear_obs();
    bus.req0 = 1'b1;
    bus.lim0 = W'(5);
    step();
    bus.lim0 = W'(1);
    step();
    bus.req1 = 1'b1;
    bus.lim1 = W'(2);
    run_sweep_drop(200);
    chk("midchange_max_val", max_val, 5);
    chk("midchange_grants", gnt_order.size(), 1);
    run_sweep_drop(200);
    chk("midchange_second_owner", int'(gnt_order[1]), 2);

    // Reset mid-sweep at value 2, then requester 0 wins next contest
    phase = "midreset";
    bus.req0 = 1'b1;
    bus.lim0 = W'(5);
    step_until_val2(50);
    async_reset("midreset_async");
    clear_obs();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.lim0 = W'(0);
    bus.lim1 = W'(0);
    run_sweep_drop(50);
    chk("midreset_first_owner", int'(gnt_order[0]), 1);
    run_sweep_drop(50);
    chk("midreset_second_owner", int'(gnt_order[1]), 2);

    // Owner drops req at value 2
    phase = "dropreq";
    clear_obs();
    bus.req0 = 1'b1;
    bus.lim0 = W'(4);
    step_until_val2(50);
    bus.req0 = 1'b0;
    run_sweep_drop(100);
`ifdef SWEEP_ABORT_EN
    chk("dropreq_done_count", done_cnt, 0);
    chk("dropreq_max_val", max_val, 2);
`else
    chk("dropreq_done_count", done_cnt, 1);
    chk("dropreq_max_val", max_val, 4);
`endif

    // Randomized traffic
    phase = "random";
    for (int n = 0; n < 800; n++) begin
      if (!bus.req0 && $urandom_range(0, 3) == 0) bus.req0 = 1'b1;
      if (!bus.req1 && $urandom_range(0, 3) == 0) bus.req1 = 1'b1;
      bus.lim0 = W'($urandom_range(0, 7));
      bus.lim1 = W'($urandom_range(0, 7));
`ifdef SWEEP_ABORT_EN
      if (cur.valid && $urandom_range(0, 39) == 0) drop_owner();
`endif
      step();
      if (cur.done) drop_owner();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    run_sweep_drop(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
